// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    if (w > 1) return $clog2(w);
    return 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Full adder built from two half_adder cells and an OR gate.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  half_adder u_ha1 (
    .a     (s0),
    .b     (cin),
    .sum   (sum),
    .carry (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Existing half adder cell: sum and carry of two bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands accepted by handshake, summed LSB-first one bit
// per clock, result returned by a second handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned       CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   a_sr_q,      a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,      b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q,    sum_sr_d;
  logic               carry_q,     carry_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_sum_q,   out_sum_d;
  logic               out_cout_q,  out_cout_d;
  logic               busy_q,      busy_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sr_d  = in_a;
          b_sr_d  = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry_d  = fa_cout;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // First DONE cycle moves the finished sum into the output registers.
        if (!out_valid_q) begin
          out_sum_d   = sum_sr_q;
          out_cout_d  = carry_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 4 and 1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid;
  logic [2:0] in_cin;
  logic [2:0] out_ready;
  logic [7:0] in_a [3];
  logic [7:0] in_b [3];
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] out_cout;
  logic [2:0] busy;
  logic [7:0] osum8;
  logic [3:0] osum4;
  logic [0:0] osum1;
  logic [7:0] sum_x [3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(osum8), .out_cout(out_cout[0]), .busy(busy[0])
  );

  serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1][3:0]), .in_b(in_b[1][3:0]), .in_cin(in_cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(osum4), .out_cout(out_cout[1]), .busy(busy[1])
  );

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2][0:0]), .in_b(in_b[2][0:0]), .in_cin(in_cin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(osum1), .out_cout(out_cout[2]), .busy(busy[2])
  );

  always_comb begin
    sum_x[0] = osum8;
    sum_x[1] = 8'(osum4);
    sum_x[2] = 8'(osum1);
  end

  typedef struct {
    int         s;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  vec_t tbl [14];

  function automatic int wid(input int s);
    return (s == 0) ? 8 : ((s == 1) ? 4 : 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer addition truncated to the instance width.
  task automatic model(input int s, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] es, output logic ec);
    int mask;
    int full;
    mask = (1 << wid(s)) - 1;
    full = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
    es   = 8'(full & mask);
    ec   = 1'((full >> wid(s)) & 1);
  endtask

  task automatic start_op(input int s, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input string nm);
    chk({nm, "/in_ready_idle"}, 32'(in_ready[s]), 32'd1);
    in_valid[s] = 1'b1;
    in_a[s]     = a;
    in_b[s]     = b;
    in_cin[s]   = cin;
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    in_a[s]     = 8'($urandom);
    in_b[s]     = 8'($urandom);
    in_cin[s]   = 1'($urandom);
    chk({nm, "/busy_run"}, 32'(busy[s]), 32'd1);
    chk({nm, "/in_ready_run"}, 32'(in_ready[s]), 32'd0);
  endtask

  task automatic wait_valid(input int s, input string nm);
    int lat;
    lat = 0;
    while (!out_valid[s] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "/latency"}, 32'(lat), 32'(wid(s) + 1));
  endtask

  task automatic finish_op(input int s, input logic [7:0] es, input logic ec,
                           input string nm, input int stalls);
    repeat (stalls) begin
      @(posedge clk); #1;
    end
    chk({nm, "/out_valid"}, 32'(out_valid[s]), 32'd1);
    chk({nm, "/sum"}, 32'(sum_x[s]), 32'(es));
    chk({nm, "/cout"}, 32'(out_cout[s]), 32'(ec));
    out_ready[s] = 1'b1;
    @(posedge clk); #1;
    out_ready[s] = 1'b0;
    chk({nm, "/out_valid_after"}, 32'(out_valid[s]), 32'd0);
    chk({nm, "/in_ready_after"}, 32'(in_ready[s]), 32'd1);
    chk({nm, "/busy_after"}, 32'(busy[s]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] es;
    logic       ec;
    int         bad;

    tbl[0]  = '{0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[1]  = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3]  = '{0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[4]  = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5]  = '{0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tbl[6]  = '{0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1, 8'h0F, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[8]  = '{1, 8'h09, 8'h06, 1'b1, 8'h00, 1'b1};
    tbl[9]  = '{1, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    tbl[10] = '{2, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{2, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1};
    tbl[12] = '{2, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[13] = '{2, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};

    rst       = 1'b1;
    in_valid  = '0;
    in_cin    = '0;
    out_ready = '0;
    for (int s = 0; s < 3; s++) begin
      in_a[s] = '0;
      in_b[s] = '0;
    end

    // Reset state on every instance.
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset%0d/in_ready", s), 32'(in_ready[s]), 32'd1);
      chk($sformatf("reset%0d/out_valid", s), 32'(out_valid[s]), 32'd0);
      chk($sformatf("reset%0d/out_sum", s), 32'(sum_x[s]), 32'd0);
      chk($sformatf("reset%0d/out_cout", s), 32'(out_cout[s]), 32'd0);
      chk($sformatf("reset%0d/busy", s), 32'(busy[s]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].cin, nm);
      wait_valid(tbl[i].s, nm);
      finish_op(tbl[i].s, tbl[i].es, tbl[i].ec, nm, 0);
    end

    // Stalled result holds while new operands are offered and ignored.
    start_op(0, 8'h3C, 8'h41, 1'b0, "hold");
    wait_valid(0, "hold");
    in_valid[0] = 1'b1;
    in_a[0]     = 8'hFF;
    in_b[0]     = 8'hFF;
    in_cin[0]   = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold/sum", 32'(sum_x[0]), 32'h7D);
      chk("hold/cout", 32'(out_cout[0]), 32'd0);
      chk("hold/in_ready", 32'(in_ready[0]), 32'd0);
      chk("hold/out_valid", 32'(out_valid[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    finish_op(0, 8'h7D, 1'b0, "hold", 0);
    @(posedge clk); #1;
    chk("hold/not_queued", 32'(busy[0]), 32'd0);

    // Reset aborts an operation after its third RUN cycle.
    start_op(0, 8'hAA, 8'h55, 1'b0, "abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort/in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort/busy", 32'(busy[0]), 32'd0);
    chk("abort/out_valid", 32'(out_valid[0]), 32'd0);
    chk("abort/out_sum", 32'(sum_x[0]), 32'd0);
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid[0]) bad++;
    end
    chk("abort/no_valid_pulse", 32'(bad), 32'd0);
    start_op(0, 8'h12, 8'h34, 1'b0, "post_abort");
    wait_valid(0, "post_abort");
    finish_op(0, 8'h46, 1'b0, "post_abort", 0);

    // Reset wins over a same-cycle input handshake.
    in_valid[0] = 1'b1;
    in_a[0]     = 8'h01;
    in_b[0]     = 8'h02;
    rst         = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_prio/busy", 32'(busy[0]), 32'd0);
    chk("rst_prio/in_ready", 32'(in_ready[0]), 32'd1);

    // Random 8-bit operands with random output stalls.
    for (int i = 0; i < 40; i++) begin
      string nm;
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      model(0, a, b, cin, es, ec);
      nm = $sformatf("rnd8 %0h+%0h+%0d", a, b, cin);
      start_op(0, a, b, cin, nm);
      wait_valid(0, nm);
      finish_op(0, es, ec, nm, int'($urandom_range(0, 3)));
    end

    // Exhaustive 4-bit sweep with random output stalls.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          string nm;
          a   = 8'(ia);
          b   = 8'(ib);
          cin = 1'(ic);
          model(1, a, b, cin, es, ec);
          nm = $sformatf("exh4 %0h+%0h+%0d", a, b, cin);
          start_op(1, a, b, cin, nm);
          wait_valid(1, nm);
          finish_op(1, es, ec, nm, int'($urandom_range(0, 2)));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
